acl_poll_sequencer: RTL and testbench



---
 rtl/acl_pkg.sv | 61 ++++++
 rtl/acl_tilt_map.sv | 31 +++
 rtl/acl_poll_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_acl_poll_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/acl_pkg.sv
// Shared constants, configuration burst contents and FSM state encoding for the ADXL362 poll sequencer.
// Define ACL_FILTER_CFG_EN to prepend a FILTER_CTL write to the configuration burst.
package acl_pkg;

  localparam logic [7:0] CMD_WRITE      = 8'h0A;
  localparam logic [7:0] CMD_READ       = 8'h0B;
  localparam logic [7:0] REG_XDATA_L    = 8'h0E;
  localparam logic [7:0] REG_FILTER_CTL = 8'h2C;
  localparam logic [7:0] REG_POWER_CTL  = 8'h2D;
  localparam logic [7:0] FILTER_CTL_VAL = 8'h13;
  localparam logic [7:0] POWER_CTL_MEAS = 8'h02;

`ifdef ACL_FILTER_CFG_EN
  localparam int CFG_LEN = 4;
`else
  localparam int CFG_LEN = 3;
`endif
  localparam int RD_LEN = 4;

  typedef enum logic [2:0] {
    WAIT_PWR,
    CFG_SETUP,
    CFG_BYTE,
    CFG_HOLD,
    IDLE,
    RD_SETUP,
    RD_BYTE,
    RD_HOLD
  } state_t;

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    logic [7:0] b;
`ifdef ACL_FILTER_CFG_EN
    // FILTER_CTL and POWER_CTL are adjacent, so one auto-increment write covers both.
    case (idx)
      2'd0:    b = CMD_WRITE;
      2'd1:    b = REG_FILTER_CTL;
      2'd2:    b = FILTER_CTL_VAL;
      default: b = POWER_CTL_MEAS;
    endcase
`else
    case (idx)
      2'd0:    b = CMD_WRITE;
      2'd1:    b = REG_POWER_CTL;
      default: b = POWER_CTL_MEAS;
    endcase
`endif
    return b;
  endfunction

  function automatic logic [7:0] rd_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = CMD_READ;
      2'd1:    b = REG_XDATA_L;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/acl_tilt_map.sv
// Maps a 12-bit signed X sample to a saturated 4-bit tilt intensity and left/right flags.
module acl_tilt_map #(
  parameter int DEADZONE = 1
) (
  input  logic [11:0] i_x,
  output logic [3:0]  o_intensity,
  output logic        o_left,
  output logic        o_right
);

  function automatic logic [11:0] abs12(input logic signed [11:0] v);
    // -2048 negates to bit pattern 0x800, which read unsigned is the correct 2048.
    return v[11] ? 12'(-v) : 12'(v);
  endfunction

  function automatic logic [3:0] sat4(input logic [5:0] v);
    return (v > 6'd15) ? 4'hF : v[3:0];
  endfunction

  logic signed [11:0] w_xs;
  logic        [11:0] w_mag;
  logic        [3:0]  w_int;

  assign w_xs        = i_x;
  assign w_mag       = abs12(w_xs);
  assign w_int       = sat4(w_mag[11:6]);
  assign o_intensity = w_int;
  assign o_left      = !w_xs[11] && (w_int > 4'(DEADZONE));
  assign o_right     =  w_xs[11] && (w_int > 4'(DEADZONE));

endmodule

// File: rtl/acl_poll_sequencer.sv
// ADXL362 SPI transaction sequencer: one configuration burst, then periodic X-axis reads.
// Build option ACL_FILTER_CFG_EN selects the longer configuration burst (see acl_pkg).
module acl_poll_sequencer
  import acl_pkg::*;
#(
  parameter int STARTUP_CYCLES = 24000,
  parameter int POLL_DIV       = 40000,
  parameter int CS_GAP         = 4,
  parameter int BYTE_TIMEOUT   = 64,
  parameter int DEADZONE       = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        byte_start,
  output logic [7:0]  byte_tx,
  input  logic        byte_done,
  input  logic [7:0]  byte_rx,
  output logic        cs_n,
  output logic        cfg_done,
  output logic [11:0] acl_x,
  output logic        sample_valid,
  output logic        tilt_left,
  output logic        tilt_right,
  output logic [3:0]  tilt_intensity,
  output logic        fault
);

  localparam int GAP_MAX = (STARTUP_CYCLES > CS_GAP) ? STARTUP_CYCLES : CS_GAP;
  localparam int CNT_W   = $clog2(GAP_MAX + 1);
  localparam int POLL_W  = $clog2(POLL_DIV + 1);
  localparam int TMO_W   = $clog2(BYTE_TIMEOUT + 1);

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [POLL_W-1:0]   r_poll;
  logic [TMO_W-1:0]    r_tmo;
  logic [1:0]          r_idx, w_idx_n;
  logic                r_wait, r_recover;
  logic [7:0]          r_xl_p0;
  logic                r_byte_start, r_cs_n, r_cfg_done, r_fault;
  logic [7:0]          r_byte_tx, w_tx;
  logic [11:0]         r_acl_x_p1;
  logic                r_vld_p1, r_left_p1, r_right_p1;
  logic [3:0]          r_int_p1;

  logic                w_issue, w_done_ok, w_expired, w_tmo, w_cfg_set;
  logic                w_xl_cap, w_sample, w_gap_end;
  logic [11:0]         w_x_p0;
  logic [3:0]          w_int_p0;
  logic                w_left_p0, w_right_p0;

  assign w_done_ok = r_wait && byte_done;
  assign w_expired = r_wait && !byte_done && (r_tmo == TMO_W'(BYTE_TIMEOUT));
  assign w_gap_end = (r_cnt == CNT_W'(CS_GAP - 1));
  assign w_x_p0    = {byte_rx[3:0], r_xl_p0};

  acl_tilt_map #(
    .DEADZONE (DEADZONE)
  ) u_tilt (
    .i_x         (w_x_p0),
    .o_intensity (w_int_p0),
    .o_left      (w_left_p0),
    .o_right     (w_right_p0)
  );

  always_comb begin
    w_next    = r_state;
    w_issue   = 1'b0;
    w_idx_n   = r_idx + 2'd1;
    w_tmo     = 1'b0;
    w_cfg_set = 1'b0;
    w_xl_cap  = 1'b0;
    w_sample  = 1'b0;
    case (r_state)
      WAIT_PWR: if (r_cnt == CNT_W'(STARTUP_CYCLES - 1)) w_next = CFG_SETUP;
      CFG_SETUP: if (w_gap_end) begin
        w_next  = CFG_BYTE;
        w_issue = 1'b1;
        w_idx_n = 2'd0;
      end
      CFG_BYTE: begin
        if (w_done_ok) begin
          if (r_idx == 2'(CFG_LEN - 1)) w_next = CFG_HOLD;
          else                          w_issue = 1'b1;
        end else if (w_expired) begin
          w_tmo  = 1'b1;
          w_next = CFG_HOLD;
        end
      end
      CFG_HOLD: if (w_gap_end) begin
        // A hold entered through a timeout replays the burst instead of resuming polling.
        if (r_recover) begin
          w_next = CFG_SETUP;
        end else begin
          w_next    = IDLE;
          w_cfg_set = 1'b1;
        end
      end
      IDLE: if (r_poll == POLL_W'(POLL_DIV - 1)) w_next = RD_SETUP;
      RD_SETUP: if (w_gap_end) begin
        w_next  = RD_BYTE;
        w_issue = 1'b1;
        w_idx_n = 2'd0;
      end
      RD_BYTE: begin
        if (w_done_ok) begin
          if (r_idx == 2'(RD_LEN - 1)) begin
            w_next   = RD_HOLD;
            w_sample = 1'b1;
          end else begin
            w_issue  = 1'b1;
            w_xl_cap = (r_idx == 2'd2);
          end
        end else if (w_expired) begin
          w_tmo  = 1'b1;
          w_next = CFG_HOLD;
        end
      end
      RD_HOLD: if (w_gap_end) w_next = IDLE;
      default: w_next = WAIT_PWR;
    endcase
    w_tx = (r_state == CFG_SETUP || r_state == CFG_BYTE) ? cfg_byte(w_idx_n) : rd_byte(w_idx_n);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= WAIT_PWR;
      r_cnt        <= '0;
      r_poll       <= '0;
      r_tmo        <= '0;
      r_idx        <= '0;
      r_wait       <= 1'b0;
      r_recover    <= 1'b0;
      r_xl_p0      <= '0;
      r_byte_start <= 1'b0;
      r_byte_tx    <= '0;
      r_cs_n       <= 1'b1;
      r_cfg_done   <= 1'b0;
      r_fault      <= 1'b0;
      r_acl_x_p1   <= '0;
      r_int_p1     <= '0;
      r_left_p1    <= 1'b0;
      r_right_p1   <= 1'b0;
      r_vld_p1     <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_cs_n       <= !(w_next inside {CFG_SETUP, CFG_BYTE, RD_SETUP, RD_BYTE});
      r_byte_start <= w_issue;
      if (w_issue) begin
        r_wait    <= 1'b1;
        r_tmo     <= '0;
        r_idx     <= w_idx_n;
        r_byte_tx <= w_tx;
      end else if (w_done_ok || w_tmo) begin
        r_wait <= 1'b0;
      end else if (r_wait) begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (w_tmo) begin
        r_fault   <= 1'b1;
        r_recover <= 1'b1;
      end else if (r_state == CFG_HOLD && w_next == CFG_SETUP) begin
        r_recover <= 1'b0;
      end
      if (w_cfg_set) r_cfg_done <= 1'b1;
      // Poll period includes transaction time, so the counter keeps running outside IDLE.
      if (r_state == CFG_HOLD || (r_state == IDLE && w_next == RD_SETUP))
        r_poll <= '0;
      else if (r_cfg_done && r_poll != POLL_W'(POLL_DIV - 1))
        r_poll <= r_poll + 1'b1;
      if (w_xl_cap) r_xl_p0 <= byte_rx;
      // ---- p0 -> p1: sample outputs register together on the 4th byte_done ----
      r_vld_p1 <= w_sample;
      if (w_sample) begin
        r_acl_x_p1 <= w_x_p0;
        r_int_p1   <= w_int_p0;
        r_left_p1  <= w_left_p0;
        r_right_p1 <= w_right_p0;
      end
    end
  end

  assign byte_start     = r_byte_start;
  assign byte_tx        = r_byte_tx;
  assign cs_n           = r_cs_n;
  assign cfg_done       = r_cfg_done;
  assign fault          = r_fault;
  assign acl_x          = r_acl_x_p1;
  assign sample_valid   = r_vld_p1;
  assign tilt_left      = r_left_p1;
  assign tilt_right     = r_right_p1;
  assign tilt_intensity = r_int_p1;

endmodule

// File: tb/tb_acl_poll_sequencer.sv
// Directed bench for acl_poll_sequencer with a 16-cycle byte engine model.
`timescale 1ns/1ps
module tb_acl_poll_sequencer;

  localparam int STARTUP = 200;
  localparam int POLL    = 400;
  localparam int GAP     = 4;
  localparam int TMO     = 64;
  localparam int DZ      = 1;
`ifdef ACL_FILTER_CFG_EN
  localparam int NCFG = 4;
`else
  localparam int NCFG = 3;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        byte_done = 1'b0;
  logic [7:0]  byte_rx = 8'h00;
  logic        byte_start, cs_n, cfg_done, sample_valid, tilt_left, tilt_right, fault;
  logic [7:0]  byte_tx;
  logic [11:0] acl_x;
  logic [3:0]  tilt_intensity;

  acl_poll_sequencer #(
    .STARTUP_CYCLES (STARTUP),
    .POLL_DIV       (POLL),
    .CS_GAP         (GAP),
    .BYTE_TIMEOUT   (TMO),
    .DEADZONE       (DZ)
  ) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .byte_start     (byte_start),
    .byte_tx        (byte_tx),
    .byte_done      (byte_done),
    .byte_rx        (byte_rx),
    .cs_n           (cs_n),
    .cfg_done       (cfg_done),
    .acl_x          (acl_x),
    .sample_valid   (sample_valid),
    .tilt_left      (tilt_left),
    .tilt_right     (tilt_right),
    .tilt_intensity (tilt_intensity),
    .fault          (fault)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Byte engine model: answers every byte_start 16 cycles later, optionally dropping the 3rd byte.
  logic [7:0] rsp_xl = 8'h00, rsp_xh = 8'h00;
  bit         suppress = 1'b0;
  logic [7:0] tx_log [0:255];
  logic       txcs_log [0:255];
  int         n_tx = 0, pos = 0, sup_cyc = 0, done4_cyc = 0;

  initial begin : engine
    logic [7:0] rsp;
    int p;
    forever begin
      @(negedge Clk);
      byte_done = 1'b0;
      if (cs_n) pos = 0;
      if (byte_start && Reset_n) begin
        if (n_tx < 256) begin
          tx_log[n_tx]   = byte_tx;
          txcs_log[n_tx] = cs_n;
        end
        n_tx++;
        p = pos;
        pos++;
        if (suppress && p == 2) begin
          suppress = 1'b0;
          sup_cyc  = cyc;
          repeat (15) @(negedge Clk);
        end else begin
          rsp = (p == 2) ? rsp_xl : (p == 3) ? rsp_xh : 8'h00;
          repeat (15) @(negedge Clk);
          byte_rx   = rsp;
          byte_done = 1'b1;
          if (p == 3) done4_cyc = cyc;
        end
      end
    end
  end

  logic prev_cs = 1'b1;
  int   n_fall = 0;
  int   fall_t [0:63];
  always @(negedge Clk) begin
    prev_cs <= cs_n;
    if (prev_cs && !cs_n && n_fall < 64) begin
      fall_t[n_fall] <= cyc;
      n_fall         <= n_fall + 1;
    end
  end

  typedef struct {
    logic [7:0]  xl;
    logic [7:0]  xh;
    logic [11:0] x;
    logic [3:0]  inten;
    logic        left;
    logic        right;
  } vec_t;

  vec_t       vt [8];
  logic [7:0] exp_cfg [4];
  logic [7:0] exp_rd  [4];

  initial begin : main
    int k, rel_cyc, base_tx;
    logic [11:0] last_x;

    vt[0] = '{8'h80, 8'hFF, 12'hF80, 4'd2,  1'b0, 1'b1};
    vt[1] = '{8'h00, 8'h08, 12'h800, 4'd15, 1'b0, 1'b1};
    vt[2] = '{8'h40, 8'h00, 12'h040, 4'd1,  1'b0, 1'b0};
    vt[3] = '{8'hC0, 8'hFF, 12'hFC0, 4'd1,  1'b0, 1'b0};
    vt[4] = '{8'h00, 8'h04, 12'h400, 4'd15, 1'b1, 1'b0};
    vt[5] = '{8'h80, 8'hF0, 12'h080, 4'd2,  1'b1, 1'b0};
    vt[6] = '{8'hFF, 8'hF7, 12'h7FF, 4'd15, 1'b1, 1'b0};
    vt[7] = '{8'h7F, 8'h00, 12'h07F, 4'd1,  1'b0, 1'b0};
`ifdef ACL_FILTER_CFG_EN
    exp_cfg[0] = 8'h0A; exp_cfg[1] = 8'h2C; exp_cfg[2] = 8'h13; exp_cfg[3] = 8'h02;
`else
    exp_cfg[0] = 8'h0A; exp_cfg[1] = 8'h2D; exp_cfg[2] = 8'h02; exp_cfg[3] = 8'h00;
`endif
    exp_rd[0] = 8'h0B; exp_rd[1] = 8'h0E; exp_rd[2] = 8'h00; exp_rd[3] = 8'h00;

    #1 Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_byte_start", byte_start, 0);
    chk("rst_outputs", {byte_tx, cfg_done, acl_x, sample_valid, tilt_left, tilt_right,
                        tilt_intensity, fault}, 0);

    rsp_xl  = vt[0].xl;
    rsp_xh  = vt[0].xh;
    Reset_n = 1'b1;
    rel_cyc = cyc;
    k = 0;
    while (cs_n && k < STARTUP + 50) begin @(negedge Clk); k++; end
    chk("startup_delay", cyc - rel_cyc, STARTUP);

    k = 0;
    while (!cfg_done && k < 2000) begin @(negedge Clk); k++; end
    chk("cfg_done_rise", cfg_done, 1);
    chk("cfg_cs_high", cs_n, 1);
    chk("cfg_byte_count", n_tx, NCFG);
    chk("cfg_cs_windows", n_fall, 1);
    for (int i = 0; i < NCFG; i++) begin
      chk("cfg_byte", tx_log[i], exp_cfg[i]);
      chk("cfg_byte_cs_low", txcs_log[i], 0);
    end

    for (int i = 0; i < 8; i++) begin
      rsp_xl = vt[i].xl;
      rsp_xh = vt[i].xh;
      k = 0;
      while (!sample_valid && k < 2 * POLL + 200) begin @(negedge Clk); k++; end
      chk("sample_valid", sample_valid, 1);
      chk("sample_latency", cyc - done4_cyc, 1);
      chk("acl_x", acl_x, vt[i].x);
      chk("tilt_intensity", tilt_intensity, vt[i].inten);
      chk("tilt_left", tilt_left, vt[i].left);
      chk("tilt_right", tilt_right, vt[i].right);
      @(negedge Clk);
      chk("sample_valid_pulse", sample_valid, 0);
    end
    for (int i = 0; i < 4; i++) begin
      chk("rd_byte", tx_log[NCFG + i], exp_rd[i]);
      chk("rd_byte_cs_low", txcs_log[NCFG + i], 0);
    end
    chk("rd_byte_total", n_tx, NCFG + 32);
    chk("poll_period_a", fall_t[2] - fall_t[1], POLL);
    chk("poll_period_b", fall_t[8] - fall_t[7], POLL);
    chk("fault_clear", fault, 0);

    last_x   = acl_x;
    base_tx  = n_tx;
    suppress = 1'b1;
    k = 0;
    while (!fault && k < 2 * POLL + 400) begin @(negedge Clk); k++; end
    chk("tmo_fault", fault, 1);
    chk("tmo_latency", cyc - sup_cyc, TMO + 1);
    chk("tmo_cs_high", cs_n, 1);
    chk("tmo_acl_x_kept", acl_x, last_x);
    chk("tmo_cfg_done_kept", cfg_done, 1);
    k = 0;
    while (n_tx < base_tx + 3 + NCFG && k < 2000) begin @(negedge Clk); k++; end
    for (int i = 0; i < NCFG; i++) chk("replay_byte", tx_log[base_tx + 3 + i], exp_cfg[i]);
    repeat (40) @(negedge Clk);
    chk("replay_done_state", {cs_n, cfg_done, fault, sample_valid}, 4'b1110);
    chk("replay_acl_x_kept", acl_x, last_x);

    k = 0;
    while (!byte_start && k < 2 * POLL + 200) begin @(negedge Clk); k++; end
    chk("mid_txn_reached", {byte_start, cs_n}, 2'b10);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_cs_n", cs_n, 1);
    chk("async_rst_outputs", {byte_start, byte_tx, cfg_done, acl_x, sample_valid, tilt_left,
                              tilt_right, tilt_intensity, fault}, 0);
    repeat (30) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (20) @(negedge Clk);
    chk("post_rst_idle", {cs_n, cfg_done, fault, byte_start}, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
